// File: rtl/idli_pkg.sv
// Shared types for the idli bit-serial core: widths, ALU opcodes, execute FSM states.
package idli_pkg;

    typedef logic [15:0] data_t;
    typedef logic [3:0]  slice_t;
    typedef logic [3:0]  reg_t;
    typedef logic [1:0]  slice_idx_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_ROL = 4'd7,
        ALU_ROR = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        EX_IDLE  = 2'd0,
        EX_ALIGN = 2'd1,
        EX_RUN   = 2'd2
    } ex_state_t;

    localparam slice_idx_t SLICE_LAST = 2'd3;

    function automatic logic op_is_right(input alu_op_t op);
        return (op == ALU_SHR) || (op == ALU_ROR);
    endfunction

    function automatic logic op_is_logic(input alu_op_t op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/idli_ex_slice_m.sv
// Combinational 4-bit slice ALU; shift edge forcing is the caller's job.
module idli_ex_slice_m
    import idli_pkg::*;
(
    input  alu_op_t op,
    input  slice_t  lhs,
    input  slice_t  rhs,
    input  logic    prev,
    input  logic    next,
    input  logic    cin,
    output slice_t  res,
    output logic    cout
);

    logic [4:0] sum_s;
    logic [4:0] diff_s;

    // One slice of the selected operation plus its carry-out.
    always_comb begin
        sum_s  = {1'b0, lhs} + {1'b0, rhs} + {4'b0000, cin};
        diff_s = {1'b0, lhs} + {1'b0, ~rhs} + {4'b0000, cin};
        res    = sum_s[3:0];
        cout   = sum_s[4];
        case (op)
            ALU_SUB: begin
                res  = diff_s[3:0];
                cout = diff_s[4];
            end
            ALU_AND: begin
                res  = lhs & rhs;
                cout = 1'b0;
            end
            ALU_OR: begin
                res  = lhs | rhs;
                cout = 1'b0;
            end
            ALU_XOR: begin
                res  = lhs ^ rhs;
                cout = 1'b0;
            end
            ALU_SHR, ALU_ROR: begin
                res  = {next, lhs[3:1]};
                cout = lhs[0];
            end
            ALU_SHL, ALU_ROL: begin
                res  = {lhs[2:0], prev};
                cout = lhs[3];
            end
            default: begin
                res  = sum_s[3:0];
                cout = sum_s[4];
            end
        endcase
    end

endmodule

// File: rtl/idli_ex_m.sv
// Bit-serial execute unit: streams four 4-bit slices per op through the slice ALU.
// Optional feature: define IDLI_EX_ROTATE_EN to enable ROL/ROR (else they act as SHL/SHR).
module idli_ex_m
    import idli_pkg::*;
(
    input  logic       i_ex_gck,
    input  logic       i_ex_rst,
    input  logic       i_ex_valid,
    output logic       o_ex_ready,
    input  alu_op_t    i_ex_op,
    input  reg_t       i_ex_lhs,
    input  reg_t       i_ex_rhs,
    input  reg_t       i_ex_dst,
    output reg_t       o_ex_rf_lhs,
    output reg_t       o_ex_rf_rhs,
    input  slice_t     i_ex_rf_lhs_data,
    input  slice_t     i_ex_rf_rhs_data,
    input  logic       i_ex_rf_lhs_next,
    input  logic       i_ex_rf_lhs_prev,
    output reg_t       o_ex_rf_dst,
    output logic       o_ex_rf_dst_en,
    output slice_t     o_ex_rf_dst_data,
    output slice_idx_t o_ex_slice,
    output logic       o_ex_done,
    output logic       o_ex_carry,
    output logic       o_ex_zero
);

    ex_state_t  state_r, state_nxt_s;
    slice_idx_t slice_r;
    alu_op_t    op_r, eff_op_s;
    reg_t       lhs_r, rhs_r, dst_r;
    logic       carry_r, zero_r, done_r, flag_carry_r, flag_zero_r;
    logic       ready_s, accept_s, run_s, last_s, first_s;
    logic       prev_s, next_s, cin_s, cout_s, fin_carry_s;
    slice_t     res_s;

    // Free-running slice counter shared with the register file rotation.
    always_ff @(posedge i_ex_gck or posedge i_ex_rst) begin
        if (i_ex_rst) begin
            slice_r <= 2'd0;
        end else begin
            slice_r <= slice_r + 2'd1;
        end
    end

    // FSM next state and ready; RUN always starts on slice 0.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        case (state_r)
            EX_IDLE: begin
                ready_s = 1'b1;
                if (i_ex_valid) begin
                    state_nxt_s = (slice_r == SLICE_LAST) ? EX_RUN : EX_ALIGN;
                end else begin
                    state_nxt_s = EX_IDLE;
                end
            end
            EX_ALIGN: begin
                if (slice_r == SLICE_LAST) begin
                    state_nxt_s = EX_RUN;
                end else begin
                    state_nxt_s = EX_ALIGN;
                end
            end
            EX_RUN: begin
                if (slice_r == SLICE_LAST) begin
                    ready_s     = 1'b1;
                    state_nxt_s = i_ex_valid ? EX_RUN : EX_IDLE;
                end else begin
                    state_nxt_s = EX_RUN;
                end
            end
            default: begin
                state_nxt_s = EX_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_ex_gck or posedge i_ex_rst) begin
        if (i_ex_rst) begin
            state_r <= EX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the accepted instruction; selects are driven straight from here.
    always_ff @(posedge i_ex_gck or posedge i_ex_rst) begin
        if (i_ex_rst) begin
            op_r  <= ALU_ADD;
            lhs_r <= 4'd0;
            rhs_r <= 4'd0;
            dst_r <= 4'd0;
        end else if (accept_s) begin
            op_r  <= i_ex_op;
            lhs_r <= i_ex_lhs;
            rhs_r <= i_ex_rhs;
            dst_r <= i_ex_dst;
        end else begin
            op_r  <= op_r;
            lhs_r <= lhs_r;
            rhs_r <= rhs_r;
            dst_r <= dst_r;
        end
    end

    // Operand conditioning: rotate folding, shift edge forcing and carry-in.
    always_comb begin
        accept_s = ready_s & i_ex_valid;
        run_s    = (state_r == EX_RUN);
        first_s  = (slice_r == 2'd0);
        last_s   = run_s && (slice_r == SLICE_LAST);
`ifdef IDLI_EX_ROTATE_EN
        eff_op_s = op_r;
`else
        case (op_r)
            ALU_ROL: eff_op_s = ALU_SHL;
            ALU_ROR: eff_op_s = ALU_SHR;
            default: eff_op_s = op_r;
        endcase
`endif
        if ((eff_op_s == ALU_SHL) && first_s) begin
            prev_s = 1'b0;
        end else begin
            prev_s = i_ex_rf_lhs_prev;
        end
        if ((eff_op_s == ALU_SHR) && (slice_r == SLICE_LAST)) begin
            next_s = 1'b0;
        end else begin
            next_s = i_ex_rf_lhs_next;
        end
        cin_s = first_s ? (eff_op_s == ALU_SUB) : carry_r;
    end

    idli_ex_slice_m u_slice (
        .op   (eff_op_s),
        .lhs  (i_ex_rf_lhs_data),
        .rhs  (i_ex_rf_rhs_data),
        .prev (prev_s),
        .next (next_s),
        .cin  (cin_s),
        .res  (res_s),
        .cout (cout_s)
    );

    // Right shifts report the bit lost at slice 0, kept in the carry flop.
    always_comb begin
        if (op_is_logic(eff_op_s)) begin
            fin_carry_s = 1'b0;
        end else if (op_is_right(eff_op_s)) begin
            fin_carry_s = carry_r;
        end else begin
            fin_carry_s = cout_s;
        end
    end

    // Per-slice carry/zero accumulation and completion flags.
    always_ff @(posedge i_ex_gck or posedge i_ex_rst) begin
        if (i_ex_rst) begin
            carry_r      <= 1'b0;
            zero_r       <= 1'b0;
            done_r       <= 1'b0;
            flag_carry_r <= 1'b0;
            flag_zero_r  <= 1'b0;
        end else begin
            done_r <= last_s;
            if (run_s) begin
                carry_r <= (!first_s && op_is_right(eff_op_s)) ? carry_r : cout_s;
                zero_r  <= (first_s ? 1'b1 : zero_r) & (res_s == 4'd0);
            end else begin
                carry_r <= carry_r;
                zero_r  <= zero_r;
            end
            if (last_s) begin
                flag_carry_r <= fin_carry_s;
                flag_zero_r  <= zero_r & (res_s == 4'd0);
            end else begin
                flag_carry_r <= flag_carry_r;
                flag_zero_r  <= flag_zero_r;
            end
        end
    end

    assign o_ex_ready       = ready_s;
    assign o_ex_rf_lhs      = lhs_r;
    assign o_ex_rf_rhs      = rhs_r;
    assign o_ex_rf_dst      = dst_r;
    assign o_ex_rf_dst_en   = run_s;
    assign o_ex_rf_dst_data = run_s ? res_s : 4'd0;
    assign o_ex_slice       = slice_r;
    assign o_ex_done        = done_r;
    assign o_ex_carry       = flag_carry_r;
    assign o_ex_zero        = flag_zero_r;

endmodule

// File: tb/tb_idli_ex_m.sv
// Directed bench for idli_ex_m with a rotating register-file model.
module tb_idli_ex_m;
    import idli_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_ex_valid;
    logic       o_ex_ready;
    alu_op_t    i_ex_op;
    reg_t       i_ex_lhs, i_ex_rhs, i_ex_dst;
    reg_t       o_ex_rf_lhs, o_ex_rf_rhs, o_ex_rf_dst;
    slice_t     lhs_data, rhs_data, o_ex_rf_dst_data;
    logic       lhs_next, lhs_prev;
    logic       o_ex_rf_dst_en;
    slice_idx_t o_ex_slice;
    logic       o_ex_done, o_ex_carry, o_ex_zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int base;
    logic [15:0] rf [16];
    logic  ld_en;
    reg_t  ld_idx;
    data_t ld_val;
    logic  prev_save, bit0_save;
    int    done_q[$];
    int    wr_q[$];

    always #5 clk = ~clk;

    idli_ex_m dut (
        .i_ex_gck         (clk),
        .i_ex_rst         (rst),
        .i_ex_valid       (i_ex_valid),
        .o_ex_ready       (o_ex_ready),
        .i_ex_op          (i_ex_op),
        .i_ex_lhs         (i_ex_lhs),
        .i_ex_rhs         (i_ex_rhs),
        .i_ex_dst         (i_ex_dst),
        .o_ex_rf_lhs      (o_ex_rf_lhs),
        .o_ex_rf_rhs      (o_ex_rf_rhs),
        .i_ex_rf_lhs_data (lhs_data),
        .i_ex_rf_rhs_data (rhs_data),
        .i_ex_rf_lhs_next (lhs_next),
        .i_ex_rf_lhs_prev (lhs_prev),
        .o_ex_rf_dst      (o_ex_rf_dst),
        .o_ex_rf_dst_en   (o_ex_rf_dst_en),
        .o_ex_rf_dst_data (o_ex_rf_dst_data),
        .o_ex_slice       (o_ex_slice),
        .o_ex_done        (o_ex_done),
        .o_ex_carry       (o_ex_carry),
        .o_ex_zero        (o_ex_zero)
    );

    // Register file read side: neighbour bits come from pre-write values.
    always_comb begin
        base     = 32'(o_ex_slice) * 4;
        lhs_data = rf[o_ex_rf_lhs][base +: 4];
        rhs_data = rf[o_ex_rf_rhs][base +: 4];
        lhs_next = (o_ex_slice == 2'd3) ? bit0_save : rf[o_ex_rf_lhs][base + 4];
        lhs_prev = (o_ex_slice == 2'd0) ? rf[o_ex_rf_lhs][15] : prev_save;
    end

    // Register file write side; r0 discards writes.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_save <= lhs_data[3];
        if (o_ex_slice == 2'd0) bit0_save <= lhs_data[0];
        if (ld_en) rf[ld_idx] <= ld_val;
        else if (o_ex_rf_dst_en && o_ex_rf_dst != 4'd0) rf[o_ex_rf_dst][base +: 4] <= o_ex_rf_dst_data;
    end

    always @(negedge clk) begin
        if (o_ex_done) done_q.push_back(cyc);
        if (o_ex_rf_dst_en) wr_q.push_back(cyc);
    end

    task automatic load(input reg_t idx, input data_t v);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input alu_op_t op, input reg_t l, input reg_t r, input reg_t d, output int acc);
        @(negedge clk);
        i_ex_valid = 1'b1; i_ex_op = op; i_ex_lhs = l; i_ex_rhs = r; i_ex_dst = d;
        for (int i = 0; i < 8 && !o_ex_ready; i++) @(negedge clk);
        tests++;
        if (!o_ex_ready) begin
            fails++;
            $display("FAIL issue_ready: ready=%b required 1", o_ex_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1 i_ex_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        for (int i = 0; i < 24 && done_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        tests++;
        if (done_q.size() < n) begin
            fails++;
            $display("FAIL done_timeout: dones=%0d required %0d", done_q.size(), n);
        end
    endtask

    task automatic check_result(input string name, input reg_t r, input data_t exp_v,
                                input logic exp_c, input logic exp_z);
        tests++;
        if (rf[r] !== exp_v) begin
            fails++;
            $display("FAIL %s_value: got %h required %h", name, rf[r], exp_v);
        end
        tests++;
        if (o_ex_carry !== exp_c || o_ex_zero !== exp_z) begin
            fails++;
            $display("FAIL %s_flags: carry=%b zero=%b required carry=%b zero=%b",
                     name, o_ex_carry, o_ex_zero, exp_c, exp_z);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (o_ex_ready !== 1'b1 || o_ex_slice !== 2'd0 || o_ex_rf_dst_en !== 1'b0 ||
            o_ex_rf_dst_data !== 4'd0 || o_ex_done !== 1'b0 || o_ex_carry !== 1'b0 ||
            o_ex_zero !== 1'b0 || o_ex_rf_lhs !== 4'd0 || o_ex_rf_rhs !== 4'd0 || o_ex_rf_dst !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b slice=%0d en=%b data=%h done=%b c=%b z=%b sel=%h/%h/%h required 1 0 0 0 0 0 0 0/0/0",
                     o_ex_ready, o_ex_slice, o_ex_rf_dst_en, o_ex_rf_dst_data, o_ex_done,
                     o_ex_carry, o_ex_zero, o_ex_rf_lhs, o_ex_rf_rhs, o_ex_rf_dst);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if (o_ex_slice !== 2'(k % 4)) begin
                fails++;
                $display("FAIL slice_count: got %0d required %0d", o_ex_slice, k % 4);
            end
        end
    endtask

    task automatic test_add();
        int acc;
        load(4'd1, 16'h00FF);
        load(4'd2, 16'h0001);
        done_q.delete(); wr_q.delete();
        issue(ALU_ADD, 4'd1, 4'd2, 4'd3, acc);
        wait_dones(1);
        check_result("add", 4'd3, 16'h0100, 1'b0, 1'b0);
        tests++;
        if (wr_q.size() != 4 || done_q[0] - wr_q[0] != 4) begin
            fails++;
            $display("FAIL add_timing: writes=%0d done_gap=%0d required 4 4", wr_q.size(), done_q[0] - wr_q[0]);
        end
        tests++;
        if (wr_q[0] - acc < 1 || wr_q[0] - acc > 4) begin
            fails++;
            $display("FAIL add_latency: got %0d required 1..4", wr_q[0] - acc);
        end
        @(negedge clk);
        tests++;
        if (o_ex_done !== 1'b0 || o_ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL add_done_pulse: done=%b ready=%b required 0 1", o_ex_done, o_ex_ready);
        end
    endtask

    task automatic test_sub_inplace();
        int acc;
        load(4'd1, 16'h1234);
        done_q.delete(); wr_q.delete();
        issue(ALU_SUB, 4'd1, 4'd1, 4'd1, acc);
        wait_dones(1);
        check_result("sub", 4'd1, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_shifts();
        int acc;
        load(4'd1, 16'h8001);
        done_q.delete();
        issue(ALU_SHR, 4'd1, 4'd0, 4'd2, acc);
        wait_dones(1);
        check_result("shr", 4'd2, 16'h4000, 1'b1, 1'b0);
        done_q.delete();
        issue(ALU_SHL, 4'd1, 4'd0, 4'd3, acc);
        wait_dones(1);
        check_result("shl", 4'd3, 16'h0002, 1'b1, 1'b0);
        load(4'd4, 16'h0001);
        done_q.delete();
        issue(ALU_ROR, 4'd4, 4'd0, 4'd5, acc);
        wait_dones(1);
`ifdef IDLI_EX_ROTATE_EN
        check_result("ror", 4'd5, 16'h8000, 1'b1, 1'b0);
`else
        check_result("ror", 4'd5, 16'h0000, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_boundary();
        int acc;
        load(4'd6, 16'hFFFF);
        load(4'd7, 16'h0001);
        done_q.delete();
        issue(ALU_ADD, 4'd6, 4'd7, 4'd8, acc);
        wait_dones(1);
        check_result("add_wrap", 4'd8, 16'h0000, 1'b1, 1'b1);
        load(4'd6, 16'h00F0);
        load(4'd7, 16'h0F00);
        done_q.delete(); wr_q.delete();
        issue(ALU_OR, 4'd6, 4'd7, 4'd0, acc);
        wait_dones(1);
        tests++;
        if (wr_q.size() != 4 || o_ex_carry !== 1'b0 || o_ex_zero !== 1'b0) begin
            fails++;
            $display("FAIL or_r0: writes=%0d carry=%b zero=%b required 4 0 0", wr_q.size(), o_ex_carry, o_ex_zero);
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1;
        load(4'd4, 16'h1111);
        load(4'd5, 16'h2222);
        load(4'd6, 16'h00FF);
        done_q.delete(); wr_q.delete();
        issue(ALU_ADD, 4'd4, 4'd5, 4'd5, acc0);
        issue(ALU_XOR, 4'd5, 4'd6, 4'd7, acc1);
        wait_dones(2);
        check_result("b2b_xor", 4'd7, 16'h33CC, 1'b0, 1'b0);
        tests++;
        if (rf[5] !== 16'h3333) begin
            fails++;
            $display("FAIL b2b_add: got %h required 3333", rf[5]);
        end
        tests++;
        if (wr_q.size() != 8 || wr_q[7] - wr_q[0] != 7 || done_q[1] - done_q[0] != 4) begin
            fails++;
            $display("FAIL b2b_timing: writes=%0d span=%0d done_gap=%0d required 8 7 4",
                     wr_q.size(), wr_q[7] - wr_q[0], done_q[1] - done_q[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int acc;
        load(4'd1, 16'hAAAA);
        load(4'd2, 16'h1111);
        issue(ALU_ADD, 4'd1, 4'd2, 4'd9, acc);
        for (int i = 0; i < 8 && !(o_ex_rf_dst_en && o_ex_slice == 2'd1); i++) @(negedge clk);
        tests++;
        if (!(o_ex_rf_dst_en && o_ex_slice == 2'd1)) begin
            fails++;
            $display("FAIL rst_reach_slice1: en=%b slice=%0d required 1 1", o_ex_rf_dst_en, o_ex_slice);
        end
        #1 rst = 1'b1;
        #1;
        done_q.delete();
        tests++;
        if (o_ex_rf_dst_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_dst_en: got %b required 0", o_ex_rf_dst_en);
        end
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (o_ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_ready: got %b required 1", o_ex_ready);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL rst_no_done: dones=%0d required 0", done_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; i_ex_valid = 1'b0; i_ex_op = ALU_ADD;
        i_ex_lhs = 4'd0; i_ex_rhs = 4'd0; i_ex_dst = 4'd0;
        ld_en = 1'b0; ld_idx = 4'd0; ld_val = 16'h0000;
        test_reset();
        test_add();
        test_sub_inplace();
        test_shifts();
        test_boundary();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
